// File: rtl/cordic_rect_polar.sv
// cordic_rect_polar: iterative vectoring-mode CORDIC converting signed (x, y) to magnitude and binary angle
module cordic_rect_polar #(
  parameter int W     = 8,
  parameter int AW    = 8,
  parameter int ITER  = 8,
  parameter int GUARD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W:0]          r_out,
  output logic [AW-1:0]       theta_out,
  output logic                busy
);
  localparam int XW  = W + 2 + GUARD;
  localparam int AAW = AW + GUARD;
  localparam int IW  = ITER > 1 ? $clog2(ITER) : 1;
  localparam int KF  = 9;

  typedef enum logic [2:0] {IDLE, PREROT, ROTATE, SCALE, DONE} state_t;

  // atan(2^-i) in binary-angle units with GUARD fraction bits, elaboration-time only
  function automatic int atan_lut(input int i);
    real z, t, s;
    z = 1.0;
    for (int k = 0; k < i; k++) z = z / 2.0;
    s = 0.0;
    t = z;
    for (int k = 0; k < 60; k++) begin
      s = s + (((k % 2) != 0) ? -t : t) / (2 * k + 1);
      t = t * z * z;
    end
    if (i == 0) s = 0.7853981633974483;
    return $rtoi(s * (2.0 ** AAW) / 6.283185307179586 + 0.5);
  endfunction

  logic [AAW-1:0] atan_tab [ITER];

  for (genvar j = 0; j < ITER; j++) begin : g_atan
    assign atan_tab[j] = AAW'(atan_lut(j));
  end

  state_t                state_q, state_d;
  logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
  logic [AAW-1:0]        acc_q, acc_d;
  logic [IW-1:0]         it_q, it_d;
  logic                  zero_q, zero_d;
  logic [W:0]            r_q, r_d;
  logic [AW-1:0]         th_q, th_d;
  logic signed [XW+KF-1:0] xs, ks;

  // gain compensation K = 1/2 + 1/8 - 1/64 - 1/512, with KF extra bits so the shifts lose nothing
  assign xs = {x_q, {KF{1'b0}}};
  assign ks = (xs >>> 1) + (xs >>> 3) - (xs >>> 6) - (xs >>> 9);

  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign r_out     = r_q;
  assign theta_out = th_q;

  // state and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      it_q    <= '0;
      zero_q  <= 1'b0;
      r_q     <= '0;
      th_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      it_q    <= it_d;
      zero_q  <= zero_d;
      r_q     <= r_d;
      th_q    <= th_d;
    end
  end

  // next state: latch, fold left half-plane into right, rotate y toward zero, scale
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    it_d    = it_q;
    zero_d  = zero_q;
    r_d     = r_q;
    th_d    = th_q;
    case (state_q)
      IDLE: if (in_valid) begin
        x_d     = XW'(x_in) <<< GUARD;
        y_d     = XW'(y_in) <<< GUARD;
        state_d = PREROT;
      end
      PREROT: begin
        x_d     = x_q[XW-1] ? -x_q : x_q;
        y_d     = x_q[XW-1] ? -y_q : y_q;
        acc_d   = x_q[XW-1] ? {1'b1, {(AAW-1){1'b0}}} : '0;
        zero_d  = x_q == '0 && y_q == '0;
        it_d    = '0;
        state_d = ROTATE;
      end
      ROTATE: begin
        x_d     = y_q[XW-1] ? x_q - (y_q >>> it_q) : x_q + (y_q >>> it_q);
        y_d     = y_q[XW-1] ? y_q + (x_q >>> it_q) : y_q - (x_q >>> it_q);
        acc_d   = y_q[XW-1] ? acc_q - atan_tab[it_q] : acc_q + atan_tab[it_q];
        it_d    = it_q + IW'(1);
        state_d = it_q == IW'(ITER - 1) ? SCALE : ROTATE;
      end
      SCALE: begin
        r_d     = zero_q ? '0 : (W+1)'(ks >>> (KF + GUARD));
        th_d    = zero_q ? '0 : acc_q[AAW-1:GUARD];
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cordic_rect_polar.sv
// tb_cordic_rect_polar: directed and random checks of the CORDIC converter against ideal sqrt/atan2
module tb_cordic_rect_polar;
  localparam int W = 8, AW = 8, ITER = 8, GUARD = 4;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [W-1:0] x_in = '0, y_in = '0;
  logic in_ready, out_valid, busy;
  logic [W:0] r_out;
  logic [AW-1:0] theta_out;
  int checks = 0, errors = 0;

  cordic_rect_polar #(.W(W), .AW(AW), .ITER(ITER), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .r_out(r_out), .theta_out(theta_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // exact comparison
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // tolerance comparison; mod > 0 compares on a circle (angle wrap)
  task automatic chk_tol(input string tag, input int obs, input real exp, input real tol, input int mod);
    real d;
    logic ok;
    d = real'(obs) - exp;
    if (mod > 0) begin
      while (d >= mod / 2.0) d = d - mod;
      while (d < -mod / 2.0) d = d + mod;
    end
    ok = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%f+-%f", tag, obs, exp, tol);
    end
  endtask

  function automatic real ideal_r(input int x, input int y);
    return $sqrt(real'(x * x + y * y));
  endfunction

  function automatic real ideal_th(input int x, input int y);
    real a;
    a = $atan2(real'(y), real'(x)) * (2.0 ** AW) / 6.283185307179586;
    if (a < 0.0) a = a + 2.0 ** AW;
    return a;
  endfunction

  // present one operand, optionally keep in_valid high with junk while busy, wait for out_valid
  task automatic run_op(input int x, input int y, input logic spam,
                        output int lat, output int r, output int th);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    x_in = W'(x);
    y_in = W'(y);
    @(posedge clk);
    #1;
    in_valid = spam;
    x_in = W'($urandom);
    y_in = W'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (spam && lat == 3) chk("busy_ignore_ready", int'(in_ready), 0);
    end
    r = int'(r_out);
    th = int'(theta_out);
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", int'(out_valid), 0);
    chk("release_ready", int'(in_ready), 1);
  endtask

  task automatic op_check(input string tag, input int x, input int y,
                          input real er, input real et, input real tol);
    int lat, r, th;
    run_op(x, y, 1'b0, lat, r, th);
    chk({tag, "_lat"}, lat, ITER + 2);
    chk_tol({tag, "_r"}, r, er, tol, 0);
    chk_tol({tag, "_theta"}, th, et, tol, 1 << AW);
    release_op();
  endtask

  initial begin
    int lat, r, th, x, y;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_r", int'(r_out), 0);
    chk("rst_theta", int'(theta_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 0, 1'b0, lat, r, th);
    chk("zero_lat", lat, ITER + 2);
    chk("zero_r", r, 0);
    chk("zero_theta", th, 0);
    release_op();

    // (3,4) with in_valid held high during the operation and 5 cycles of backpressure
    run_op(3, 4, 1'b1, lat, r, th);
    chk("p34_lat", lat, ITER + 2);
    chk_tol("p34_r", r, 5.0, 1.0, 0);
    chk_tol("p34_theta", th, 38.0, 1.0, 256);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_r", int'(r_out), r);
      chk("hold_theta", int'(theta_out), th);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    release_op();

    op_check("ax_px", 5, 0, 5.0, 0.0, 1.0);
    op_check("ax_py", 0, 5, 5.0, 64.0, 1.0);
    op_check("ax_nx", -8, 0, 8.0, 128.0, 1.0);
    op_check("ax_ny", 0, -5, 5.0, 192.0, 1.0);
    op_check("ext_nn", -128, -128, 181.0, 160.0, 1.0);
    run_op(127, -1, 1'b0, lat, r, th);
    chk_tol("ext_wrap_r", r, 127.0, 1.0, 0);
    chk_tol("ext_wrap_theta", th, 255.5, 0.5, 256);
    release_op();

    // random operands against the ideal result; tolerance covers output truncation plus CORDIC residual
    for (int k = 0; k < 40; k++) begin
      x = int'($urandom_range(0, 255)) - 128;
      y = int'($urandom_range(0, 255)) - 128;
      op_check("rnd", x, y, ideal_r(x, y), ideal_th(x, y), 2.0);
    end

    // abort in ROTATE by reset, then a fresh operation
    @(negedge clk);
    in_valid = 1'b1;
    x_in = -8'sd128;
    y_in = -8'sd128;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_r", int'(r_out), 0);
    chk("abort_theta", int'(theta_out), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    op_check("p86", 8, 6, 10.0, 26.0, 1.0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
